// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
package uart_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a push into a full FIFO is
// taken when a pop happens on the same edge.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO store strobes queued in a FIFO and serialised as 8N1, LSB first.
// Frames drain back-to-back with no idle gap while the FIFO holds data.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int FIFO_DEPTH   = 16,
  localparam int CW           = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          mmio_wea,
  input  logic [31:0]   mmio_dat,
  input  logic          clr_ovf,
  output logic          tx,
  output logic          mmio_read,
  output logic          tx_busy,
  output logic [CW:0]   fifo_count,
  output logic          overflow
);
  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t                   state;
  logic [BW-1:0]               baud;
  logic [2:0]                  bit_idx;
  logic [UART_DATA_BITS-1:0]   shift;
  logic [UART_DATA_BITS-1:0]   fifo_dout;
  logic                        fifo_full, fifo_empty;
  logic                        baud_done, pop, wr_acc;
  logic                        unused_hi;

  assign unused_hi = ^mmio_dat[31:UART_DATA_BITS];

  assign baud_done = (baud == BAUD_LAST);
  // Pop at IDLE or at the last stop-bit cycle so the next start bit follows directly.
  assign pop    = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));
  assign wr_acc = mmio_wea && (!fifo_full || pop);

  sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .Rst   (Rst),
    .push  (wr_acc),
    .pop   (pop),
    .din   (mmio_dat[UART_DATA_BITS-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            shift   <= fifo_dout;
            baud    <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            state   <= DATA;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              state <= START;
              shift <= fifo_dout;
              tx    <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A dropped write sets overflow even when clr_ovf arrives the same cycle.
  always_ff @(posedge clk) begin
    if (Rst) begin
      mmio_read <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mmio_read <= wr_acc;
      if (mmio_wea && !wr_acc) overflow <= 1'b1;
      else if (clr_ovf)        overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        mmio_wea = 1'b0;
  logic [31:0] mmio_dat = '0;
  logic        clr_ovf = 1'b0;
  logic        tx, mmio_read, tx_busy, overflow;
  logic [4:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .Rst        (Rst),
    .mmio_wea   (mmio_wea),
    .mmio_dat   (mmio_dat),
    .clr_ovf    (clr_ovf),
    .tx         (tx),
    .mmio_read  (mmio_read),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame image: bit0 = start, bits 8:1 = data LSB first, bit9 = stop.
  typedef struct {
    logic [31:0] dat;
    logic [9:0]  frame;
  } vec_t;
  vec_t vt[4];

  logic [7:0] rxq[$];
  int         rxs[$];
  int         rx_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Independent line receiver: samples each bit mid-period.
  initial begin : rx_mon
    logic [7:0] b;
    int         s;
    logic       ok;
    forever begin
      @(posedge clk); #1;
      if (!Rst && tx === 1'b0) begin
        s = cyc; ok = 1'b1; b = '0;
        repeat (2) @(posedge clk);
        #1;
        if (tx !== 1'b0) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
          repeat (4) @(posedge clk);
          #1;
          b[j] = tx;
        end
        repeat (4) @(posedge clk);
        #1;
        if (tx !== 1'b1) ok = 1'b0;
        rxq.push_back(b);
        rxs.push_back(s);
        if (!ok) rx_bad++;
      end
    end
  end

  initial begin : stim
    logic [9:0] got;
    int glitch, busy, acks, bad, t;

    vt[0] = '{32'h0000_0055, 10'h2AA};
    vt[1] = '{32'hDEAD_BE41, 10'h282};
    vt[2] = '{32'h0000_00FF, 10'h3FE};
    vt[3] = '{32'hFFFF_FF00, 10'h200};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_mmio_read", mmio_read, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk) Rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_tx", tx, 1);

    // Single frames, table-driven
    foreach (vt[k]) begin
      @(negedge clk);
      mmio_wea = 1'b1;
      mmio_dat = vt[k].dat;
      @(posedge clk); #1;
      mmio_wea = 1'b0;
      chk("ack_pulse", mmio_read, 1);
      chk("tx_before_start", tx, 1);
      chk("count_after_write", fifo_count, 1);
      @(posedge clk); #1;
      chk("ack_one_cycle", mmio_read, 0);
      got = '0; glitch = 0; busy = 0;
      for (int i = 0; i < 10 * CPB; i++) begin
        if (i > 0) begin
          @(posedge clk); #1;
        end
        if (i % CPB == 0) got[i / CPB] = tx;
        else if (tx !== got[i / CPB]) glitch++;
        if (tx_busy === 1'b1) busy++;
      end
      chk("frame_bits", {22'd0, got}, {22'd0, vt[k].frame});
      chk("bit_stable", glitch, 0);
      chk("busy_cycles", busy, 10 * CPB);
      @(posedge clk); #1;
      chk("busy_drop", tx_busy, 0);
      chk("idle_after_frame", tx, 1);
    end

    // 18 back-to-back writes: one popped, 16 stored, last dropped
    repeat (5) @(posedge clk);
    rxq.delete(); rxs.delete(); rx_bad = 0; acks = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      mmio_wea = 1'b1;
      mmio_dat = {24'hABCDEF, 8'(8'h30 + i)};
      @(posedge clk); #1;
      if (mmio_read === 1'b1) acks++;
    end
    chk("burst_acks", acks, 17);
    chk("burst_count_full", fifo_count, 16);
    chk("burst_overflow", overflow, 1);

    // Dropped write with clr_ovf: set wins; then clr alone clears
    @(negedge clk);
    mmio_dat = 32'h0000_0099;
    clr_ovf  = 1'b1;
    @(posedge clk); #1;
    mmio_wea = 1'b0;
    clr_ovf  = 1'b0;
    chk("ovf_set_beats_clr", overflow, 1);
    chk("drop_no_ack", mmio_read, 0);
    chk("drop_count_held", fifo_count, 16);
    @(negedge clk) clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    t = 0;
    while (rxq.size() < 17 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("burst_frames_rx", rxq.size(), 17);
    bad = 0;
    for (int i = 0; i < rxq.size() && i < 17; i++) begin
      if (rxq[i] !== 8'(8'h30 + i)) bad++;
      if (i > 0 && rxs[i] - rxs[i-1] != 10 * CPB) bad++;
    end
    chk("burst_order_contig", bad, 0);
    chk("burst_framing", rx_bad, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("burst_drained", fifo_count, 0);
    chk("burst_idle", tx_busy, 0);

    // Reset mid-frame with bytes queued
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mmio_wea = 1'b1;
      mmio_dat = 32'h0000_00A0 + i;
      @(posedge clk); #1;
    end
    mmio_wea = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("pre_rst_busy", tx_busy, 1);
    chk("pre_rst_queued", fifo_count, 5);
    @(negedge clk) Rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx", tx, 1);
    chk("abort_count", fifo_count, 0);
    chk("abort_busy", tx_busy, 0);
    chk("abort_ack", mmio_read, 0);
    @(negedge clk) Rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("no_frames_after_rst", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
